// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: operand forwarding selects, load-use and long-latency scoreboard
// stalls, and a saturating stall-cycle counter, sitting beside the ID/EX register.
module hazard_fwd_unit #(
    parameter int NREGS  = 32,
    parameter int LL_LAT = 4,
    parameter int SCNT_W = 16,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RW-1:0]     id_rs1,
    input  logic [RW-1:0]     id_rs2,
    input  logic [RW-1:0]     idex_rs1,
    input  logic [RW-1:0]     idex_rs2,
    input  logic [RW-1:0]     idex_rd,
    input  logic              idex_memread,
    input  logic [RW-1:0]     exmem_rd,
    input  logic              exmem_regwrite,
    input  logic [RW-1:0]     memwb_rd,
    input  logic              memwb_regwrite,
    input  logic              issue_ll,
    input  logic [RW-1:0]     issue_rd,
    output logic [1:0]        FwdA,
    output logic [1:0]        FwdB,
    output logic              stall,
    output logic              bubble,
    output logic [NREGS-1:0]  busy,
    output logic [SCNT_W-1:0] stall_cnt
);
    localparam int CW = $clog2(LL_LAT + 1);

    logic [CW-1:0]     cnt_q [NREGS];
    logic [CW-1:0]     cnt_d [NREGS];
    logic [SCNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic              lu, sb_hit, accept;

    // EX/MEM is the younger producer, so it takes priority over MEM/WB
    function automatic logic [1:0] fwd_sel(
        input logic [RW-1:0] s,
        input logic [RW-1:0] em_rd,
        input logic          em_we,
        input logic [RW-1:0] mw_rd,
        input logic          mw_we
    );
        return (em_we && em_rd != '0 && em_rd == s) ? 2'b10 :
               (mw_we && mw_rd != '0 && mw_rd == s) ? 2'b01 : 2'b00;
    endfunction

    always_comb begin
        FwdA = fwd_sel(idex_rs1, exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite);
        FwdB = fwd_sel(idex_rs2, exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite);
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < NREGS; i++)
            busy[i] = cnt_q[i] != '0;
    end

    always_comb begin
        lu     = idex_memread && idex_rd != '0 && (idex_rd == id_rs1 || idex_rd == id_rs2);
        sb_hit = busy[id_rs1] || busy[id_rs2];
        stall  = lu || sb_hit;
        bubble = stall;
        accept = issue_ll && !stall && issue_rd != '0;
    end

    // a reload on re-issue (WAW) takes precedence over the per-cycle decrement
    always_comb begin
        for (int i = 0; i < NREGS; i++)
            cnt_d[i] = (accept && issue_rd == RW'(i)) ? CW'(LL_LAT) :
                       busy[i] ? cnt_q[i] - CW'(1) : cnt_q[i];
    end

    assign stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + SCNT_W'(1) : stall_cnt_q;
    assign stall_cnt   = stall_cnt_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++)
            cnt_q[i] <= rst ? '0 : cnt_d[i];
        stall_cnt_q <= rst ? '0 : stall_cnt_d;
    end
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: directed and random stimulus; a spec-level model pushes expected
// outputs per cycle into a queue that a negedge monitor pops and compares.
module tb_hazard_fwd_unit;
    localparam int NREGS = 32;
    localparam int LL    = 4;
    localparam int SW    = 8;
    localparam int RW    = 5;

    typedef struct {
        logic [1:0]       fa, fb;
        logic             st;
        logic [NREGS-1:0] busy;
        logic [SW-1:0]    sc;
    } exp_t;

    logic clk = 0, rst;
    logic [RW-1:0] id_rs1, id_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd, issue_rd;
    logic idex_memread, exmem_regwrite, memwb_regwrite, issue_ll;
    logic [1:0] FwdA, FwdB;
    logic stall, bubble;
    logic [NREGS-1:0] busy;
    logic [SW-1:0] stall_cnt;

    int   n_tests = 0, n_fail = 0;
    exp_t q[$];
    int   iss [NREGS];
    bit   iss_v [NREGS];
    int   scnt = 0, cyc = 0;
    bit   known = 0;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.NREGS(NREGS), .LL_LAT(LL), .SCNT_W(SW)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd), .idex_memread(idex_memread),
        .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
        .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
        .issue_ll(issue_ll), .issue_rd(issue_rd),
        .FwdA(FwdA), .FwdB(FwdB), .stall(stall), .bubble(bubble),
        .busy(busy), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("FwdA", 32'(FwdA), 32'(e.fa));
            chk("FwdB", 32'(FwdB), 32'(e.fb));
            chk("stall", 32'(stall), 32'(e.st));
            chk("bubble", 32'(bubble), 32'(e.st));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("stall_cnt", 32'(stall_cnt), 32'(e.sc));
        end
    end

    function automatic logic [1:0] m_fwd(input logic [RW-1:0] s);
        if (exmem_regwrite && exmem_rd != 0 && exmem_rd == s) return 2'b10;
        if (memwb_regwrite && memwb_rd != 0 && memwb_rd == s) return 2'b01;
        return 2'b00;
    endfunction

    // busy for the LL cycles following the cycle in which the issue was accepted
    function automatic bit m_busy(input int r);
        return iss_v[r] && (cyc - iss[r]) >= 1 && (cyc - iss[r]) <= LL;
    endfunction

    task automatic tick();
        exp_t e;
        logic [NREGS-1:0] b;
        bit st;
        for (int r = 0; r < NREGS; r++) b[r] = m_busy(r);
        st = (idex_memread && idex_rd != 0 && (idex_rd == id_rs1 || idex_rd == id_rs2))
             || b[id_rs1] || b[id_rs2];
        if (known) begin
            e.fa = m_fwd(idex_rs1); e.fb = m_fwd(idex_rs2);
            e.st = st; e.busy = b; e.sc = SW'(scnt);
            q.push_back(e);
        end
        if (rst) begin
            for (int r = 0; r < NREGS; r++) iss_v[r] = 0;
            scnt = 0;
            known = 1;
        end else begin
            if (issue_ll && !st && issue_rd != 0) begin
                iss[issue_rd] = cyc;
                iss_v[issue_rd] = 1;
            end
            if (st && scnt < 2**SW - 1) scnt++;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {id_rs1, id_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd, issue_rd} = '0;
        {idex_memread, exmem_regwrite, memwb_regwrite, issue_ll} = '0;
    endtask

    initial begin
        for (int r = 0; r < NREGS; r++) begin iss[r] = 0; iss_v[r] = 0; end
        rst = 1;
        idle();
        @(posedge clk); #1;
        tick(); tick();
        rst = 0;
        exmem_regwrite = 1; exmem_rd = 5; memwb_regwrite = 1; memwb_rd = 5; idex_rs1 = 5;
        tick();
        exmem_regwrite = 0;
        tick();
        idle(); idex_rs2 = 0; exmem_rd = 0; exmem_regwrite = 1;
        tick();
        idle(); idex_rs2 = 7;
        tick();
        idle(); idex_memread = 1; idex_rd = 3; id_rs2 = 3;
        tick();
        idex_rd = 0;
        tick();
        idle(); issue_ll = 1; issue_rd = 9;
        tick();
        issue_ll = 0; id_rs1 = 9;
        repeat (5) tick();
        idle(); issue_ll = 1; issue_rd = 9;
        tick();
        issue_ll = 0;
        repeat (3) tick();
        issue_ll = 1;
        tick();
        issue_ll = 0;
        repeat (5) tick();
        idle(); idex_memread = 1; idex_rd = 3; id_rs1 = 3; issue_ll = 1; issue_rd = 12;
        tick();
        idle();
        repeat (2) tick();
        idle(); idex_memread = 1; idex_rd = 3; id_rs1 = 3;
        repeat (2**SW + 3) tick();
        idle(); issue_ll = 1; issue_rd = 6;
        tick();
        issue_ll = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        repeat (2) tick();
        repeat (3000) begin
            id_rs1 = RW'($urandom_range(0, 7)); id_rs2 = RW'($urandom_range(0, 7));
            idex_rs1 = RW'($urandom_range(0, 7)); idex_rs2 = RW'($urandom_range(0, 7));
            idex_rd = RW'($urandom_range(0, 7)); exmem_rd = RW'($urandom_range(0, 7));
            memwb_rd = RW'($urandom_range(0, 7)); issue_rd = RW'($urandom_range(0, 7));
            idex_memread = $urandom_range(0, 3) == 0;
            exmem_regwrite = 1'($urandom_range(0, 1));
            memwb_regwrite = 1'($urandom_range(0, 1));
            issue_ll = $urandom_range(0, 2) == 0;
            rst = $urandom_range(0, 299) == 0;
            tick();
        end
        rst = 0;
        idle();
        tick();
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
